// File: rtl/pim_axi_initiator.sv
// AXI4 INCR burst initiator: one request at a time, full AW/W/B or AR/R handshakes,
// data streamed to/from the sequencer, one done pulse per request with merged response.
module pim_axi_initiator #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // sequencer request / data side
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [7:0]            req_len,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  rd_last,
    input  logic                  rd_ready,
    output logic                  done,
    output logic [1:0]            done_resp,
    output logic                  done_err,
    // AXI write channels
    output logic [ADDR_WIDTH-1:0] awaddr,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [7:0]            awlen,
    output logic [2:0]            awsize,
    output logic [1:0]            awburst,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic                  wvalid,
    output logic                  wlast,
    input  logic                  wready,
    input  logic [1:0]            bresp,
    input  logic                  bvalid,
    output logic                  bready,
    // AXI read channels
    output logic [ADDR_WIDTH-1:0] araddr,
    output logic                  arvalid,
    input  logic                  arready,
    output logic [7:0]            arlen,
    output logic [2:0]            arsize,
    output logic [1:0]            arburst,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [1:0]            rresp,
    input  logic                  rvalid,
    input  logic                  rlast,
    output logic                  rready,
    // FSM state for checkers
    output logic [2:0]            dbg_state
);

    // Handshake rule on every channel: a transfer happens on a rising edge where
    // valid and ready are both high; a raised valid and its payload hold until then.

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        AW   = 3'd1,
        W    = 3'd2,
        B    = 3'd3,
        AR   = 3'd4,
        R    = 3'd5,
        DONE = 3'd6
    } state_t;

    localparam logic [2:0] BEAT_SIZE = 3'($clog2(DATA_WIDTH / 8));
    localparam logic [1:0] BURST_INCR = 2'b01;

    state_t     state, next_state;
    logic [7:0] len_q;
    logic [8:0] cnt_q;
    logic [1:0] acc_q;
    logic       err_q;

    logic       w_hs, r_hs, b_hs, cnt_at_len, r_err;
    logic [1:0] r_acc;

    assign w_hs       = (state == W) && wr_valid && wready;
    assign r_hs       = (state == R) && rvalid && rd_ready;
    assign b_hs       = (state == B) && bvalid && bready;
    assign cnt_at_len = (cnt_q == {1'b0, len_q});
    assign r_acc      = (rresp > acc_q) ? rresp : acc_q;
    // rlast must coincide exactly with the final counted beat
    assign r_err      = rlast ^ cnt_at_len;
    assign dbg_state  = state;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        req_ready  = 1'b0;
        wvalid     = 1'b0;
        wdata      = '0;
        wlast      = 1'b0;
        wr_ready   = 1'b0;
        rd_valid   = 1'b0;
        rd_data    = '0;
        rd_last    = 1'b0;
        rready     = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) next_state = req_write ? AW : AR;
            end
            AW: if (awvalid && awready) next_state = W;
            AR: if (arvalid && arready) next_state = R;
            W: begin
                wvalid   = wr_valid;
                wdata    = wr_data;
                wr_ready = wready;
                wlast    = cnt_at_len;
                if (w_hs && cnt_at_len) next_state = B;
            end
            B: if (b_hs) next_state = DONE;
            R: begin
                rd_valid = rvalid;
                rd_data  = rdata;
                rd_last  = rlast;
                rready   = rd_ready;
                if (r_hs && (rlast || cnt_at_len)) next_state = DONE;
            end
            DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            awvalid   <= 1'b0;
            arvalid   <= 1'b0;
            bready    <= 1'b0;
            done      <= 1'b0;
            done_resp <= 2'b00;
            done_err  <= 1'b0;
            awaddr    <= '0;
            araddr    <= '0;
            awlen     <= 8'd0;
            arlen     <= 8'd0;
            awsize    <= 3'd0;
            arsize    <= 3'd0;
            awburst   <= 2'b00;
            arburst   <= 2'b00;
            len_q     <= 8'd0;
            cnt_q     <= 9'd0;
            acc_q     <= 2'b00;
            err_q     <= 1'b0;
        end else begin
            awvalid   <= (next_state == AW);
            arvalid   <= (next_state == AR);
            // bready rises one cycle into B and drops after its handshake
            bready    <= (state == B) && !b_hs;
            done      <= (next_state == DONE);
            done_resp <= 2'b00;
            done_err  <= 1'b0;

            if (state == IDLE && req_valid) begin
                len_q   <= req_len;
                cnt_q   <= 9'd0;
                acc_q   <= 2'b00;
                err_q   <= 1'b0;
                awsize  <= BEAT_SIZE;
                arsize  <= BEAT_SIZE;
                awburst <= BURST_INCR;
                arburst <= BURST_INCR;
                if (req_write) begin
                    awaddr <= req_addr;
                    awlen  <= req_len;
                end else begin
                    araddr <= req_addr;
                    arlen  <= req_len;
                end
            end

            if (w_hs) cnt_q <= cnt_q + 9'd1;

            if (b_hs) begin
                acc_q     <= bresp;
                done_resp <= bresp;
            end

            if (r_hs) begin
                cnt_q <= cnt_q + 9'd1;
                acc_q <= r_acc;
                err_q <= err_q | r_err;
                if (rlast || cnt_at_len) begin
                    done_resp <= r_acc;
                    done_err  <= err_q | r_err;
                end
            end
        end
    end

endmodule

// File: tb/tb_pim_axi_initiator.sv
// Directed bench for pim_axi_initiator: the bench plays the sequencer and the AXI slave,
// drives at the falling edge and observes 1ns later.
module tb_pim_axi_initiator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr;
    logic [7:0]  req_len;
    logic [31:0] wr_data;
    logic        wr_valid, wr_ready;
    logic [31:0] rd_data;
    logic        rd_valid, rd_last, rd_ready;
    logic        done;
    logic [1:0]  done_resp;
    logic        done_err;
    logic [31:0] awaddr;
    logic        awvalid, awready;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [31:0] wdata;
    logic        wvalid, wlast, wready;
    logic [1:0]  bresp;
    logic        bvalid, bready;
    logic [31:0] araddr;
    logic        arvalid, arready;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid, rlast, rready;
    logic [2:0]  dbg_state;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // results filled in by the driver tasks
    int          acc_edge, a_edge, done_edge, beats, last_cnt, last_idx, data_err;
    logic [7:0]  a_len;
    logic [2:0]  a_size;
    logic [1:0]  a_burst;
    logic [31:0] a_addr;
    bit          bready_seen, timeout;
    logic [1:0]  res_resp;
    logic        res_err;

    pim_axi_initiator #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_len(req_len),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last), .rd_ready(rd_ready),
        .done(done), .done_resp(done_resp), .done_err(done_err),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready), .awlen(awlen),
        .awsize(awsize), .awburst(awburst),
        .wdata(wdata), .wvalid(wvalid), .wlast(wlast), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready), .arlen(arlen),
        .arsize(arsize), .arburst(arburst),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rlast(rlast), .rready(rready),
        .dbg_state(dbg_state)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic clear_inputs();
        req_valid = 0; req_write = 0; req_addr = 0; req_len = 0;
        wr_data = 0; wr_valid = 0; rd_ready = 0;
        awready = 0; wready = 0; bresp = 0; bvalid = 0;
        arready = 0; rdata = 0; rresp = 0; rvalid = 0; rlast = 0;
    endtask

    // sequencer + write slave; bvalid is raised the cycle after the wlast beat
    task automatic drive_write(input logic [31:0] addr, input logic [7:0] len,
                               input bit toggle, input logic [1:0] bresp_v);
        bit b_pend, b_hs;
        logic [31:0] exp_d;
        b_pend = 0; b_hs = 0;
        beats = 0; last_cnt = 0; last_idx = -1; data_err = 0;
        a_edge = -1; done_edge = -1; bready_seen = 0; timeout = 1;
        @(negedge clk);
        req_valid = 1; req_write = 1; req_addr = addr; req_len = len;
        awready = 1; wready = 1; wr_valid = 1; wr_data = 32'hDEAD_BEEF;
        bresp = bresp_v; bvalid = 0;
        acc_edge = cyc + 1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            req_valid = 0;
            if (toggle) wready = ~wready;
            exp_d = 32'hDEAD_BEEF + 32'(beats);
            wr_data = exp_d;
            if (b_hs) begin bvalid = 0; b_pend = 0; b_hs = 0; end
            else if (b_pend) bvalid = 1;
            #1;
            if (awvalid && a_edge < 0) begin
                a_edge = cyc + 1; a_len = awlen; a_size = awsize;
                a_burst = awburst; a_addr = awaddr;
            end
            if (wvalid && wr_ready) begin
                if (wdata !== exp_d) data_err++;
                if (wlast) begin last_cnt++; last_idx = beats; b_pend = 1; end
                beats++;
            end
            if (bready) bready_seen = 1;
            if (bvalid && bready) b_hs = 1;
            if (done) begin
                done_edge = cyc + 1; res_resp = done_resp; res_err = done_err;
                timeout = 0;
                break;
            end
        end
        clear_inputs();
    endtask

    // sequencer + read slave; beat k carries data k, rresp 10 on err_beat, rlast on rlast_beat
    task automatic drive_read(input logic [31:0] addr, input logic [7:0] len, input bit stalls,
                              input int err_beat, input int rlast_beat);
        bit ar_ok, r_hs;
        int sb;
        ar_ok = 0; r_hs = 0; sb = 0;
        beats = 0; last_cnt = 0; last_idx = -1; data_err = 0;
        a_edge = -1; done_edge = -1; timeout = 1;
        @(negedge clk);
        req_valid = 1; req_write = 0; req_addr = addr; req_len = len;
        arready = 1; rvalid = 0; rd_ready = 1;
        acc_edge = cyc + 1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            req_valid = 0;
            if (r_hs) begin rvalid = 0; sb++; r_hs = 0; end
            if (ar_ok && !rvalid) rvalid = stalls ? ($urandom_range(0, 1) == 1) : 1'b1;
            rdata = 32'(sb);
            rresp = (sb == err_beat) ? 2'b10 : 2'b00;
            rlast = (sb == rlast_beat);
            rd_ready = stalls ? ($urandom_range(0, 1) == 1) : 1'b1;
            #1;
            if (arvalid && a_edge < 0) begin
                a_edge = cyc + 1; a_len = arlen; a_size = arsize;
                a_burst = arburst; a_addr = araddr;
            end
            if (arvalid && arready) ar_ok = 1;
            if (rd_valid && rready) begin
                if (rd_data !== 32'(beats)) data_err++;
                if (rd_last) begin last_cnt++; last_idx = beats; end
                beats++;
                r_hs = 1;
            end
            if (done) begin
                done_edge = cyc + 1; res_resp = done_resp; res_err = done_err;
                timeout = 0;
                break;
            end
        end
        clear_inputs();
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %0b expected 1", req_ready); end
        checks++;
        if ({awvalid, arvalid, bready, done, done_err, done_resp} !== 7'd0) begin
            errors++; $display("FAIL reset_ctrl: got %0h expected 0", {awvalid, arvalid, bready, done, done_err, done_resp});
        end
        checks++;
        if ({awaddr, araddr, awlen, arlen, awsize, arsize, awburst, arburst} !== 90'd0) begin
            errors++; $display("FAIL reset_addr: got %0h expected 0", {awaddr, araddr, awlen, arlen, awsize, arsize, awburst, arburst});
        end
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_single_write();
        drive_write(32'h0000_0800, 8'd0, 1'b0, 2'b00);
        checks++;
        if (timeout !== 1'b0) begin errors++; $display("FAIL sw_timeout: got %0b expected 0", timeout); end
        checks++;
        if ({a_len, a_burst, a_size} !== {8'd0, 2'b01, 3'b010}) begin
            errors++; $display("FAIL sw_aw_fields: got len %0d burst %0b size %0b expected 0 01 010", a_len, a_burst, a_size);
        end
        checks++;
        if (a_addr !== 32'h0000_0800) begin errors++; $display("FAIL sw_awaddr: got %0h expected 800", a_addr); end
        checks++;
        if (a_edge !== acc_edge + 1) begin errors++; $display("FAIL sw_aw_latency: got %0d expected %0d", a_edge, acc_edge + 1); end
        checks++;
        if ({beats, last_idx, data_err} !== {32'd1, 32'd0, 32'd0}) begin
            errors++; $display("FAIL sw_wbeat: got beats %0d last_idx %0d data_err %0d expected 1 0 0", beats, last_idx, data_err);
        end
        checks++;
        if (bready_seen !== 1'b1) begin errors++; $display("FAIL sw_bready: got %0b expected 1", bready_seen); end
        checks++;
        if (done_edge !== acc_edge + 5) begin errors++; $display("FAIL sw_done_latency: got %0d expected %0d", done_edge, acc_edge + 5); end
        checks++;
        if ({res_resp, res_err} !== 3'b000) begin errors++; $display("FAIL sw_resp: got %0b expected 000", {res_resp, res_err}); end
        @(negedge clk); #1;
        checks++;
        if ({done, req_ready} !== 2'b01) begin errors++; $display("FAIL sw_done_pulse: got done %0b req_ready %0b expected 0 1", done, req_ready); end
    endtask

    task automatic test_write_bresp_err();
        drive_write(32'h0000_1000, 8'd1, 1'b0, 2'b10);
        checks++;
        if (done_edge !== acc_edge + 6) begin errors++; $display("FAIL wb_done_latency: got %0d expected %0d", done_edge, acc_edge + 6); end
        checks++;
        if ({beats, last_idx} !== {32'd2, 32'd1}) begin errors++; $display("FAIL wb_beats: got %0d last %0d expected 2 1", beats, last_idx); end
        checks++;
        if (res_resp !== 2'b10) begin errors++; $display("FAIL wb_resp: got %0b expected 10", res_resp); end
    endtask

    task automatic test_write_256_toggle();
        drive_write(32'h0002_0000, 8'd255, 1'b1, 2'b00);
        checks++;
        if (timeout !== 1'b0) begin errors++; $display("FAIL w256_timeout: got %0b expected 0", timeout); end
        checks++;
        if (beats !== 256) begin errors++; $display("FAIL w256_beats: got %0d expected 256", beats); end
        checks++;
        if ({last_cnt, last_idx} !== {32'd1, 32'd255}) begin
            errors++; $display("FAIL w256_wlast: got count %0d idx %0d expected 1 255", last_cnt, last_idx);
        end
        checks++;
        if ({data_err, 24'(a_len)} !== {32'd0, 24'd255}) begin errors++; $display("FAIL w256_data_len: got err %0d len %0d expected 0 255", data_err, a_len); end
        checks++;
        if (res_resp !== 2'b00) begin errors++; $display("FAIL w256_resp: got %0b expected 00", res_resp); end
    endtask

    task automatic test_read_16_stalls();
        drive_read(32'h0000_4000, 8'd15, 1'b1, -1, 15);
        checks++;
        if (timeout !== 1'b0) begin errors++; $display("FAIL r16_timeout: got %0b expected 0", timeout); end
        checks++;
        if ({a_len, a_burst, a_size, a_addr} !== {8'd15, 2'b01, 3'b010, 32'h0000_4000}) begin
            errors++; $display("FAIL r16_ar_fields: got len %0d burst %0b size %0b addr %0h", a_len, a_burst, a_size, a_addr);
        end
        checks++;
        if ({beats, data_err} !== {32'd16, 32'd0}) begin errors++; $display("FAIL r16_data: got beats %0d data_err %0d expected 16 0", beats, data_err); end
        checks++;
        if ({last_cnt, last_idx} !== {32'd1, 32'd15}) begin errors++; $display("FAIL r16_rd_last: got count %0d idx %0d expected 1 15", last_cnt, last_idx); end
        checks++;
        if ({res_resp, res_err} !== 3'b000) begin errors++; $display("FAIL r16_resp: got %0b expected 000", {res_resp, res_err}); end
    endtask

    task automatic test_read_slverr();
        drive_read(32'h0000_5000, 8'd3, 1'b0, 2, 3);
        checks++;
        if (beats !== 4) begin errors++; $display("FAIL rerr_beats: got %0d expected 4", beats); end
        checks++;
        if ({res_resp, res_err} !== 3'b100) begin errors++; $display("FAIL rerr_resp: got %0b expected 100", {res_resp, res_err}); end
    endtask

    task automatic test_read_early_rlast();
        drive_read(32'h0000_6000, 8'd3, 1'b0, -1, 1);
        checks++;
        if ({beats, last_idx} !== {32'd2, 32'd1}) begin errors++; $display("FAIL rlast_exit: got beats %0d last %0d expected 2 1", beats, last_idx); end
        checks++;
        if ({res_resp, res_err} !== 3'b001) begin errors++; $display("FAIL rlast_err: got %0b expected 001", {res_resp, res_err}); end
    endtask

    task automatic test_reset_mid_write();
        int wb;
        int done_cnt;
        bit hit;
        wb = 0; done_cnt = 0; hit = 0;
        @(negedge clk);
        req_valid = 1; req_write = 1; req_addr = 32'h0000_7000; req_len = 8'd7;
        awready = 1; wready = 1; wr_valid = 1; wr_data = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            req_valid = 0;
            wr_data = 32'(wb);
            #1;
            if (wb == 5 && wvalid) begin rst_n = 0; hit = 1; break; end
            if (wvalid && wr_ready) wb++;
        end
        checks++;
        if (hit !== 1'b1) begin errors++; $display("FAIL rst_reach_beat5: got beats %0d expected 5", wb); end
        @(negedge clk); #1;
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_req_ready: got %0b expected 1", req_ready); end
        checks++;
        if ({awvalid, arvalid, bready, done, done_err, done_resp, wvalid, wr_ready, wlast, rready, rd_valid, rd_last} !== 13'd0) begin
            errors++; $display("FAIL rst_mid_ctrl: got %0h expected 0",
                {awvalid, arvalid, bready, done, done_err, done_resp, wvalid, wr_ready, wlast, rready, rd_valid, rd_last});
        end
        checks++;
        if ({awaddr, awlen, awsize, awburst, wdata} !== 77'd0) begin
            errors++; $display("FAIL rst_mid_data: got %0h expected 0", {awaddr, awlen, awsize, awburst, wdata});
        end
        rst_n = 1;
        clear_inputs();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); #1;
            if (done) done_cnt++;
        end
        checks++;
        if (done_cnt !== 0) begin errors++; $display("FAIL rst_mid_no_done: got %0d expected 0", done_cnt); end
        drive_read(32'h0000_0040, 8'd0, 1'b0, -1, 0);
        checks++;
        if ({timeout, beats, data_err, last_idx} !== {1'b0, 32'd1, 32'd0, 32'd0}) begin
            errors++; $display("FAIL rst_then_read: got timeout %0b beats %0d data_err %0d last %0d expected 0 1 0 0", timeout, beats, data_err, last_idx);
        end
        checks++;
        if ({res_resp, res_err} !== 3'b000) begin errors++; $display("FAIL rst_then_read_resp: got %0b expected 000", {res_resp, res_err}); end
    endtask

    initial begin
        rst_n = 0;
        clear_inputs();
        test_reset();
        test_single_write();
        test_write_bresp_err();
        test_read_16_stalls();
        test_read_slverr();
        test_read_early_rlast();
        test_write_256_toggle();
        test_reset_mid_write();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
